fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 32-bit word entries; power of two, >= 2.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_flush  input  1  synchronous discard of all buffered words.
REQ-005 SHALL have port i_word_valid  input  1  fetch presents a word.
REQ-006 SHALL have port i_word  input  [0:31]  fetched instruction word, bit 0 MSB.
REQ-007 SHALL have port o_word_ready  output  1  buffer accepts a word this cycle.
REQ-008 SHALL have port o_instr_valid  output  1  complete instruction available.
REQ-009 SHALL have port o_instr  output  [0:63]  instruction to decode/identify stage.
REQ-010 SHALL have port o_prefixed  output  1  o_instr is prefix+suffix pair.
REQ-011 SHALL have port i_instr_ready  input  1  downstream consumes o_instr this cycle.

Function
REQ-012 SHALL store words in a circular FIFO: write pointer, read pointer (clog2(DEPTH) bits, natural wrap), count (clog2(DEPTH)+1 bits).
REQ-013 SHALL accept a word when i_word_valid && o_word_ready; o_word_ready SHALL equal (count < DEPTH), registered-state only, no combinational path from i_instr_ready.
REQ-014 SHALL treat the head word as a prefix when its bits [0:5] == 6'b000001.
REQ-015 Head not prefix, count >= 1: o_instr_valid=1, o_instr={head, 32'h0}, o_prefixed=0; handshake pops 1 word.
REQ-016 Head prefix, count >= 2: o_instr_valid=1, o_instr={head, head+1}, o_prefixed=1; handshake pops 2 words.
REQ-017 Head prefix, count == 1 (suffix pending): o_instr_valid=0; wait with no timeout.
REQ-018 count == 0: o_instr_valid=0, o_instr=64'h0, o_prefixed=0.
REQ-019 Output states derived from count and head opcode: EMPTY, PENDING_SUFFIX, READY; no separate state register.
REQ-020 Suffix word with opcode 000001 SHALL be passed unchanged as the second half (no legality check here).
REQ-021 Simultaneous push and pop SHALL be allowed in the same cycle, including when count == DEPTH (push blocked by REQ-013, pop proceeds); count updates by +1 - pops.
REQ-022 o_instr/o_prefixed SHALL be held stable while o_instr_valid && !i_instr_ready.
REQ-023 i_flush SHALL zero count and both pointers next cycle, overriding any push or pop that cycle; the word offered that cycle is dropped.
REQ-024 Minimum latency word-in to o_instr_valid SHALL be 1 cycle (non-prefixed) or 1 cycle after the suffix is written (prefixed).

Reset
REQ-025 On i_rst low, asynchronously: count=0, pointers=0, o_instr_valid=0, o_instr=64'h0, o_prefixed=0, o_word_ready=1 after release.
REQ-026 Reset mid-operation SHALL discard all stored words including a half-assembled prefix; storage array contents need not be cleared.

Configuration
REQ-027 Macro FETCH_BUFFER_BYPASS_EN defined: when count == 0, no flush, i_word_valid, incoming word not prefix and i_instr_ready, word SHALL appear on o_instr with o_instr_valid=1 the same cycle and SHALL NOT be written.
REQ-028 Macro undefined: no bypass path; REQ-024 latency applies to every word.

Structure
REQ-029 Shared package power_pkg SHALL hold OPCODE_PREFIX (6'b000001), typedef instr_word_t [0:31], typedef instr_full_t [0:63].
REQ-030 No sub-module; FIFO storage and pairing logic live in fetch_buffer.

Verification
REQ-031 Push 32'h38600001 (addi), i_instr_ready=1 -> next cycle o_instr=64'h38600001_00000000, o_prefixed=0, count returns 0.
REQ-032 Push 32'h06000000 then, 3 cycles later, 32'h38600005 -> o_instr_valid=0 until suffix stored, then o_instr=64'h06000000_38600005, o_prefixed=1, both popped in one handshake.
REQ-033 i_instr_ready=0, push 5 words with DEPTH=4 -> o_word_ready=0 after 4th, 5th held; release ready -> words emerge in order, none lost.
REQ-034 Full FIFO, simultaneous offered push and pop -> pop occurs, push refused that cycle, accepted next cycle.
REQ-035 Prefix stored alone, assert i_flush with a push offered -> count=0, o_instr_valid=0 next cycle, offered word absent.
REQ-036 FETCH_BUFFER_BYPASS_EN defined, empty buffer, push 32'h7C0802A6 with i_instr_ready=1 -> o_instr_valid=1 same cycle, count stays 0; undefined -> valid one cycle later.

Source files
------------

// File: rtl/power_pkg.sv
// Shared opcode constants and word types for the fetch path.
// Used by fetch_buffer and its handshake interface.
package power_pkg;

  localparam logic [0:5] OPCODE_PREFIX = 6'b000001;

  typedef logic [0:31] instr_word_t;
  typedef logic [0:63] instr_full_t;

  typedef enum logic [1:0] {
    FB_EMPTY,
    FB_PENDING,
    FB_READY
  } fb_state_e;

  function automatic logic is_prefix(instr_word_t w);
    return w[0:5] == OPCODE_PREFIX;
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle.
// master = fetch/decode driver side, slave = buffer side.
interface fetch_buffer_if;
  import power_pkg::*;

  logic        flush;
  logic        word_valid;
  instr_word_t word;
  logic        word_ready;
  logic        instr_valid;
  instr_full_t instr;
  logic        prefixed;
  logic        instr_ready;

  modport master (
    output flush, word_valid, word, instr_ready,
    input  word_ready, instr_valid, instr, prefixed
  );

  modport slave (
    input  flush, word_valid, word, instr_ready,
    output word_ready, instr_valid, instr, prefixed
  );

endinterface

// File: rtl/fetch_buffer.sv
// Word FIFO that pairs prefix+suffix into one 64-bit instruction.
// Optional same-cycle bypass when FETCH_BUFFER_BYPASS_EN is defined.
module fetch_buffer
  import power_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_word_valid,
  input  instr_word_t i_word,
  output logic        o_word_ready,
  output logic        o_instr_valid,
  output instr_full_t o_instr,
  output logic        o_prefixed,
  input  logic        i_instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  instr_word_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  instr_word_t   head, nxt;
  logic          head_pfx;
  fb_state_e     state;
  logic          bypass;
  logic          push;
  logic [1:0]    npop;
  logic [1:0]    pop_n;

  assign head     = mem_q[rd_ptr_q];
  assign nxt      = mem_q[rd_ptr_q + AW'(1)];
  assign head_pfx = is_prefix(head);

  assign o_word_ready = count_q < DEPTH_C;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = (count_q == '0) && !i_flush &&
                  i_word_valid && !is_prefix(i_word) &&
                  i_instr_ready;
`else
  assign bypass = 1'b0;
`endif

  // Output state derived from occupancy and head opcode.
  always_comb begin
    state = FB_EMPTY;
    unique case (1'b1)
      (count_q == '0):
        state = FB_EMPTY;
      (head_pfx && count_q == CW'(1)):
        state = FB_PENDING;
      default:
        state = FB_READY;
    endcase
  end

  // Instruction presentation and words consumed on handshake.
  always_comb begin
    o_instr_valid = 1'b0;
    o_instr       = '0;
    o_prefixed    = 1'b0;
    npop          = 2'd0;
    unique case (state)
      FB_READY: begin
        o_instr_valid = 1'b1;
        if (head_pfx) begin
          o_instr    = {head, nxt};
          o_prefixed = 1'b1;
          npop       = 2'd2;
        end else begin
          o_instr = {head, 32'h0};
          npop    = 2'd1;
        end
      end
      default: ;
    endcase
    if (bypass) begin
      o_instr_valid = 1'b1;
      o_instr       = {i_word, 32'h0};
      o_prefixed    = 1'b0;
      npop          = 2'd0;
    end
  end

  assign push  = i_word_valid && o_word_ready &&
                 !bypass && !i_flush;
  assign pop_n = (o_instr_valid && i_instr_ready) ?
                 npop : 2'd0;

  // Pointer/count next state; flush wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop_n);
    count_d  = count_q + CW'(push) - CW'(pop_n);
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // FIFO control registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage; contents are don't-care until counted.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_word;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH=4).
// Expectations follow FETCH_BUFFER_BYPASS_EN if defined.
module tb_fetch_buffer;
  import power_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] a [5];

  fetch_buffer_if bus ();

  fetch_buffer #(.DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_flush       (bus.flush),
    .i_word_valid  (bus.word_valid),
    .i_word        (bus.word),
    .o_word_ready  (bus.word_ready),
    .o_instr_valid (bus.instr_valid),
    .o_instr       (bus.instr),
    .o_prefixed    (bus.prefixed),
    .i_instr_ready (bus.instr_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [63:0] ins,
                         input logic p,
                         input logic [2:0] cnt);
    chk({tag, "_valid"}, 64'(bus.instr_valid), 64'(v));
    chk({tag, "_instr"}, bus.instr, ins);
    chk({tag, "_pfx"}, 64'(bus.prefixed), 64'(p));
    chk({tag, "_count"}, 64'(dut.count_q), 64'(cnt));
  endtask

  initial begin
    for (int k = 0; k < 5; k++) a[k] = 32'h11000001 + k;
    bus.flush       = 1'b0;
    bus.word_valid  = 1'b0;
    bus.word        = '0;
    bus.instr_ready = 1'b0;
    rst_n           = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 64'h0, 1'b0, 3'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_wready", 64'(bus.word_ready), 64'd1);

    // single non-prefixed word
    tick();
    bus.word_valid  = 1'b1;
    bus.word        = 32'h38600001;
    bus.instr_ready = 1'b1;
    #1;
`ifdef FETCH_BUFFER_BYPASS_EN
    chk_out("addi_byp", 1'b1, 64'h38600001_00000000,
            1'b0, 3'd0);
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk_out("addi_after", 1'b0, 64'h0, 1'b0, 3'd0);
`else
    chk_out("addi_same", 1'b0, 64'h0, 1'b0, 3'd0);
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk_out("addi_next", 1'b1, 64'h38600001_00000000,
            1'b0, 3'd1);
    tick();
    chk_out("addi_popped", 1'b0, 64'h0, 1'b0, 3'd0);
`endif

    // prefix, suffix three cycles later
    bus.word_valid = 1'b1;
    bus.word       = 32'h06000000;
    #1;
    chk("pfx_offer_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk_out("pfx_wait1", 1'b0, 64'h0, 1'b0, 3'd1);
    tick();
    chk("pfx_wait2_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    chk("pfx_wait3_valid", 64'(bus.instr_valid), 64'd0);
    bus.word_valid = 1'b1;
    bus.word       = 32'h38600005;
    #1;
    chk("sfx_offer_valid", 64'(bus.instr_valid), 64'd0);
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk_out("pair", 1'b1, 64'h06000000_38600005,
            1'b1, 3'd2);
    tick();
    chk_out("pair_popped", 1'b0, 64'h0, 1'b0, 3'd0);

    // suffix carrying prefix opcode passes unchanged
    bus.instr_ready = 1'b0;
    bus.word_valid  = 1'b1;
    bus.word        = 32'h04000000;
    tick();
    bus.word = 32'h04000001;
    #1;
    chk_out("pp_one", 1'b0, 64'h0, 1'b0, 3'd1);
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk_out("pp_pair", 1'b1, 64'h04000000_04000001,
            1'b1, 3'd2);
    bus.instr_ready = 1'b1;
    tick();
    chk_out("pp_popped", 1'b0, 64'h0, 1'b0, 3'd0);

    // fill to full with downstream stalled
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.word_valid = 1'b1;
      bus.word       = a[k];
      #1;
      chk($sformatf("fill%0d_wready", k),
          64'(bus.word_ready), 64'd1);
      tick();
    end
    bus.word = a[4];
    #1;
    chk("full_wready", 64'(bus.word_ready), 64'd0);
    chk_out("full", 1'b1, {a[0], 32'h0}, 1'b0, 3'd4);
    tick();
    chk_out("full_hold", 1'b1, {a[0], 32'h0}, 1'b0, 3'd4);

    // full: pop proceeds, push refused this cycle
    bus.instr_ready = 1'b1;
    #1;
    chk("fullpop_wready", 64'(bus.word_ready), 64'd0);
    tick();
    chk_out("fullpop", 1'b1, {a[1], 32'h0}, 1'b0, 3'd3);
    chk("fullpop_wready2", 64'(bus.word_ready), 64'd1);
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk_out("drain_a2", 1'b1, {a[2], 32'h0}, 1'b0, 3'd3);
    tick();
    chk_out("drain_a3", 1'b1, {a[3], 32'h0}, 1'b0, 3'd2);
    tick();
    chk_out("drain_a4", 1'b1, {a[4], 32'h0}, 1'b0, 3'd1);
    tick();
    chk_out("drain_end", 1'b0, 64'h0, 1'b0, 3'd0);

    // flush drops stored prefix and the offered word
    bus.instr_ready = 1'b0;
    bus.word_valid  = 1'b1;
    bus.word        = 32'h06000000;
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk_out("flush_pre", 1'b0, 64'h0, 1'b0, 3'd1);
    bus.flush      = 1'b1;
    bus.word_valid = 1'b1;
    bus.word       = 32'h38600007;
    tick();
    bus.flush      = 1'b0;
    bus.word_valid = 1'b0;
    #1;
    chk_out("flush_post", 1'b0, 64'h0, 1'b0, 3'd0);
    chk("flush_wready", 64'(bus.word_ready), 64'd1);
    bus.instr_ready = 1'b1;
    tick();
    chk_out("flush_gone", 1'b0, 64'h0, 1'b0, 3'd0);

    // asynchronous reset mid-operation
    bus.instr_ready = 1'b0;
    bus.word_valid  = 1'b1;
    bus.word        = 32'h06000000;
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk("arst_pre_count", 64'(dut.count_q), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 64'h0, 1'b0, 3'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst_wready", 64'(bus.word_ready), 64'd1);
    tick();
    chk_out("arst_after", 1'b0, 64'h0, 1'b0, 3'd0);

    // empty-buffer latency for a plain word
    bus.instr_ready = 1'b1;
    bus.word_valid  = 1'b1;
    bus.word        = 32'h7C0802A6;
    #1;
`ifdef FETCH_BUFFER_BYPASS_EN
    chk_out("mflr_same", 1'b1, 64'h7C0802A6_00000000,
            1'b0, 3'd0);
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk_out("mflr_after", 1'b0, 64'h0, 1'b0, 3'd0);
`else
    chk_out("mflr_same", 1'b0, 64'h0, 1'b0, 3'd0);
    tick();
    bus.word_valid = 1'b0;
    #1;
    chk_out("mflr_next", 1'b1, 64'h7C0802A6_00000000,
            1'b0, 3'd1);
    tick();
    chk_out("mflr_popped", 1'b0, 64'h0, 1'b0, 3'd0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
